// File: rtl/match_event_reporter.sv
// Turns matched-filter decision strobes into two-word timestamped event messages
// (header + timestamp) with a match holdoff, a small event FIFO and drop reporting.
module match_event_reporter #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIFO_AW    = 2,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mf_valid,
  input  logic        mf_match,
  input  logic [31:0] rx_timestamp,
  input  logic [15:0] holdoff_len,
  input  logic        clear_ovf,
  input  logic        evt_ready,
  output logic        evt_valid,
  output logic [31:0] evt_data,
  output logic        evt_last,
  output logic        overflow,
  output logic [15:0] event_count,
  output logic [15:0] debugbus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    TS   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic [15:0]        holdoff_cnt;
  logic [7:0]         seq;
  logic [7:0]         drop_cnt;
  logic [7:0]         fifo_cnt_ext;
  logic               qualified, fifo_full, push, drop, pop, hdr_accept;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign qualified  = mf_valid & mf_match & enable & (holdoff_cnt == 16'd0);
  assign fifo_full  = (fifo_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
  assign push       = qualified & ~fifo_full;
  assign drop       = qualified & fifo_full;
  assign hdr_accept = (state == HDR) & evt_ready;
  assign pop        = (state == TS) & evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      holdoff_cnt <= 16'd0;
    end else if (!enable) begin
      holdoff_cnt <= 16'd0;
    end else if (qualified) begin
      holdoff_cnt <= holdoff_len;
    end else if (mf_valid && holdoff_cnt != 16'd0) begin
      holdoff_cnt <= holdoff_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rx_timestamp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // The header reports drops up to the moment it is accepted; a drop landing
  // on the accept cycle is carried into the next message.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt    <= 8'd0;
      overflow    <= 1'b0;
      seq         <= 8'd0;
      event_count <= 16'd0;
    end else begin
      if (hdr_accept) begin
        drop_cnt <= drop ? 8'd1 : 8'd0;
      end else if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
      if (pop) begin
        seq         <= seq + 8'd1;
        event_count <= event_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    evt_valid  = 1'b0;
    evt_data   = 32'd0;
    evt_last   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          state_next = HDR;
        end
      end
      HDR: begin
        evt_valid = 1'b1;
        evt_data  = {MAGIC, seq, drop_cnt, 8'h00};
        if (evt_ready) begin
          state_next = TS;
        end
      end
      TS: begin
        evt_valid = 1'b1;
        evt_data  = fifo_mem[rd_ptr];
        evt_last  = 1'b1;
        // Chain straight into the next header when another entry remains.
        if (evt_ready) begin
          state_next = (fifo_cnt > (FIFO_AW+1)'(1) || push) ? HDR : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fifo_cnt_ext = 8'(fifo_cnt);
  assign debugbus     = {state, fifo_cnt_ext[2:0], (holdoff_cnt != 16'd0),
                         overflow, drop_cnt, 1'b0};

endmodule

// File: tb/tb_match_event_reporter.sv
// Self-checking bench for match_event_reporter: expected message words are queued
// as matches are driven and compared as the DUT hands them over.
module tb_match_event_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mf_valid;
  logic        mf_match;
  logic [31:0] rx_timestamp;
  logic [15:0] holdoff_len;
  logic        clear_ovf;
  logic        evt_ready;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_last;
  logic        overflow;
  logic [15:0] event_count;
  logic [15:0] debugbus;

  int          checks = 0;
  int          fails  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;
  logic        stab_en   = 1'b0;
  logic        prev_pend = 1'b0;
  logic [33:0] prev_word = '0;

  match_event_reporter dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mf_valid     (mf_valid),
    .mf_match     (mf_match),
    .rx_timestamp (rx_timestamp),
    .holdoff_len  (holdoff_len),
    .clear_ovf    (clear_ovf),
    .evt_ready    (evt_ready),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_last     (evt_last),
    .overflow     (overflow),
    .event_count  (event_count),
    .debugbus     (debugbus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic match, input logic [31:0] ts);
    mf_valid     = 1'b1;
    mf_match     = match;
    rx_timestamp = ts;
    tick();
    mf_valid     = 1'b0;
    mf_match     = 1'b0;
  endtask

  task automatic expectEvent(input logic [7:0] seq, input logic [7:0] drops, input logic [31:0] ts);
    exp_q.push_back({1'b0, 8'hA5, seq, drops, 8'h00});
    exp_q.push_back({1'b1, ts});
  endtask

  task automatic doReset();
    reset     = 1'b1;
    mf_valid  = 1'b0;
    mf_match  = 1'b0;
    clear_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !evt_valid) break;
      tick();
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    checkOutput("drain_idle", 64'(evt_valid), 64'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_word", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_w = exp_q.pop_front();
        checkOutput("evt_word", 64'({evt_last, evt_data}), 64'(exp_w));
      end
    end
    if (stab_en && !reset && prev_pend) begin
      checkOutput("hold_stable", 64'({evt_valid, evt_last, evt_data}), 64'(prev_word));
    end
    prev_pend = evt_valid && !evt_ready && !reset;
    prev_word = {1'b0, evt_valid, evt_last, evt_data};
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_valid [4];
    exp_valid = '{1'b0, 1'b1, 1'b1, 1'b0};

    enable       = 1'b1;
    holdoff_len  = 16'd0;
    evt_ready    = 1'b1;
    rx_timestamp = 32'd0;
    #1;
    doReset();

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst_valid", 64'(evt_valid), 64'd0);
    checkOutput("rst_data", 64'(evt_data), 64'd0);
    checkOutput("rst_last", 64'(evt_last), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_event_count", 64'(event_count), 64'd0);
    checkOutput("rst_debugbus", 64'(debugbus), 64'd0);
    tick();

    $display("[TB] single match");
    expectEvent(8'h00, 8'h00, 32'h0000_1234);
    applyStimulus(1'b1, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_valid_cycle%0d", i + 1), 64'(evt_valid), 64'(exp_valid[i]));
      tick();
    end
    checkOutput("t1_event_count", 64'(event_count), 64'd1);
    waitDrain(20);

    $display("[TB] holdoff");
    doReset();
    holdoff_len = 16'd3;
    expectEvent(8'h00, 8'h00, 32'd100);
    expectEvent(8'h01, 8'h00, 32'd104);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'd100 + 32'(i));
    waitDrain(40);
    checkOutput("t2_event_count", 64'(event_count), 64'd2);

    $display("[TB] overflow");
    doReset();
    holdoff_len = 16'd0;
    evt_ready   = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'd200 + 32'(i));
    checkOutput("t3_overflow", 64'(overflow), 64'd1);
    checkOutput("t3_debugbus", 64'(debugbus), 64'h6204);
    expectEvent(8'h00, 8'h02, 32'd200);
    expectEvent(8'h01, 8'h00, 32'd201);
    expectEvent(8'h02, 8'h00, 32'd202);
    expectEvent(8'h03, 8'h00, 32'd203);
    evt_ready = 1'b1;
    waitDrain(60);
    checkOutput("t3_event_count", 64'(event_count), 64'd4);
    checkOutput("t3_overflow_sticky", 64'(overflow), 64'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checkOutput("t3_overflow_cleared", 64'(overflow), 64'd0);
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd300 + 32'(i));
    clear_ovf = 1'b1;
    applyStimulus(1'b1, 32'd304);
    clear_ovf = 1'b0;
    checkOutput("t3_clear_vs_drop", 64'(overflow), 64'd1);
    expectEvent(8'h04, 8'h01, 32'd300);
    expectEvent(8'h05, 8'h00, 32'd301);
    expectEvent(8'h06, 8'h00, 32'd302);
    expectEvent(8'h07, 8'h00, 32'd303);
    evt_ready = 1'b1;
    waitDrain(60);
    checkOutput("t3_event_count_2", 64'(event_count), 64'd8);

    $display("[TB] ready toggling");
    doReset();
    evt_ready = 1'b0;
    stab_en   = 1'b1;
    expectEvent(8'h00, 8'h00, 32'hCAFE_0001);
    expectEvent(8'h01, 8'h00, 32'hCAFE_0002);
    applyStimulus(1'b1, 32'hCAFE_0001);
    applyStimulus(1'b1, 32'hCAFE_0002);
    for (int i = 0; i < 24; i++) begin
      evt_ready = ~evt_ready;
      tick();
    end
    evt_ready = 1'b1;
    waitDrain(40);
    stab_en = 1'b0;
    checkOutput("t4_event_count", 64'(event_count), 64'd2);

    $display("[TB] reset mid-message");
    doReset();
    evt_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hA500_0000});
    applyStimulus(1'b1, 32'd500);
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    @(negedge clk);
    checkOutput("t5_ts_last", 64'(evt_last), 64'd1);
    checkOutput("t5_ts_data", 64'(evt_data), 64'd500);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t5_valid_after_reset", 64'(evt_valid), 64'd0);
    checkOutput("t5_count_after_reset", 64'(event_count), 64'd0);
    tick();
    reset     = 1'b0;
    evt_ready = 1'b1;
    checkOutput("t5_hdr_consumed", 64'(exp_q.size()), 64'd0);
    expectEvent(8'h00, 8'h00, 32'd600);
    applyStimulus(1'b1, 32'd600);
    waitDrain(20);
    checkOutput("t5_event_count", 64'(event_count), 64'd1);

    $display("[TB] enable clears holdoff");
    doReset();
    holdoff_len = 16'd10;
    expectEvent(8'h00, 8'h00, 32'd700);
    applyStimulus(1'b1, 32'd700);
    applyStimulus(1'b1, 32'd701);
    checkOutput("t6_holdoff_active", 64'(debugbus[10]), 64'd1);
    enable = 1'b0;
    applyStimulus(1'b1, 32'h0000_07FF);
    checkOutput("t6_holdoff_cleared", 64'(debugbus[10]), 64'd0);
    enable = 1'b1;
    expectEvent(8'h01, 8'h00, 32'd702);
    applyStimulus(1'b1, 32'd702);
    waitDrain(30);
    checkOutput("t6_event_count", 64'(event_count), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
